// File: rtl/fft_out_serializer_pkg.sv
// Shared definitions for the FFT output path.
// - FFT_DW / FFT_N : default sample width and frame length
// - sample_t       : one signed I or Q sample
// - ser_state_t    : serializer FSM states
// - beat_bits()    : counter width for a given beat count (at least 1 bit)
package fft_pkg;

  localparam int FFT_DW = 13;
  localparam int FFT_N  = 512;

  typedef logic signed [FFT_DW-1:0] sample_t;

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } ser_state_t;

  function automatic int beat_bits(input int n_beats);
    return (n_beats > 1) ? $clog2(n_beats) : 1;
  endfunction

endpackage

// File: rtl/fft_out_serializer_if.sv
// Frame-in / beat-out bus of the FFT output serializer.
// Frame side : load (one-cycle done pulse), din_i/din_q (whole frame, valid with load)
// Beat side  : dout_i/dout_q (LANES samples), dout_valid/dout_ready handshake,
//              dout_sof/dout_eof frame markers, beat_idx
// Modports   : master = serializer (drives the beat stream)
//              slave  = environment (drives frames and ready)
interface fft_out_serializer_if
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DW,
  parameter int N_POINTS   = FFT_N,
  parameter int LANES      = 16
);

  localparam int BEAT_W = beat_bits(N_POINTS / LANES);

  logic                                  load;
  logic [N_POINTS-1:0][DATA_WIDTH-1:0]   din_i;
  logic [N_POINTS-1:0][DATA_WIDTH-1:0]   din_q;
  logic [LANES-1:0][DATA_WIDTH-1:0]      dout_i;
  logic [LANES-1:0][DATA_WIDTH-1:0]      dout_q;
  logic                                  dout_valid;
  logic                                  dout_ready;
  logic                                  dout_sof;
  logic                                  dout_eof;
  logic [BEAT_W-1:0]                     beat_idx;

  modport master (
    input  load, din_i, din_q, dout_ready,
    output dout_i, dout_q, dout_valid, dout_sof, dout_eof, beat_idx
  );

  modport slave (
    output load, din_i, din_q, dout_ready,
    input  dout_i, dout_q, dout_valid, dout_sof, dout_eof, beat_idx
  );

endinterface

// File: rtl/fft_out_serializer_ser_lane_mux.sv
// Selects one LANES-wide beat out of a held frame.
// - i_buf_i / i_buf_q : full frame, sample 0 at index 0
// - i_beat            : beat number
// - o_lane_i/o_lane_q : lane l = frame[i_beat*LANES + l]
// Purely combinational.
module ser_lane_mux #(
  parameter int DATA_WIDTH = 13,
  parameter int N_POINTS   = 512,
  parameter int LANES      = 16,
  parameter int BEAT_W     = 5
) (
  input  logic [N_POINTS-1:0][DATA_WIDTH-1:0] i_buf_i,
  input  logic [N_POINTS-1:0][DATA_WIDTH-1:0] i_buf_q,
  input  logic [BEAT_W-1:0]                   i_beat,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    o_lane_i,
  output logic [LANES-1:0][DATA_WIDTH-1:0]    o_lane_q
);

  localparam int IDX_W = (N_POINTS > 1) ? $clog2(N_POINTS) : 1;

  logic [IDX_W-1:0] w_idx;

  always_comb begin
    o_lane_i = '0;
    o_lane_q = '0;
    w_idx    = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      w_idx       = IDX_W'(int'(i_beat) * LANES + int'(l));
      o_lane_i[l] = i_buf_i[w_idx];
      o_lane_q[l] = i_buf_q[w_idx];
    end
  end

endmodule

// File: rtl/fft_out_serializer.sv
// Captures a full I/Q frame on the reorder stage's done pulse and streams it
// in natural order, LANES samples per beat, under valid/ready backpressure.
// Ports:
// - clk, rstn    : clock (rising edge), asynchronous active-low reset
// - bus          : frame input and beat output (fft_out_serializer_if.master)
// - busy         : a frame is held / streaming
// - overrun      : sticky, a load pulse arrived mid-frame and was dropped
// - clr_overrun  : synchronous clear of overrun (a coincident drop wins)
module fft_out_serializer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DW,
  parameter int N_POINTS   = FFT_N,
  parameter int LANES      = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  fft_out_serializer_if.master bus,
  output logic                 busy,
  output logic                 overrun,
  input  logic                 clr_overrun
);

  localparam int N_BEATS = N_POINTS / LANES;
  localparam int BEAT_W  = beat_bits(N_BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);

  generate
    if (N_POINTS % LANES != 0) begin : g_bad_cfg
      $fatal(1, "fft_out_serializer: N_POINTS must be a multiple of LANES");
    end
  endgenerate

  ser_state_t                          r_state;
  ser_state_t                          w_next;
  logic [N_POINTS-1:0][DATA_WIDTH-1:0] r_buf_i;
  logic [N_POINTS-1:0][DATA_WIDTH-1:0] r_buf_q;
  logic [BEAT_W-1:0]                   r_beat;
  logic                                r_overrun;

  logic                                w_stream;
  logic                                w_hs;
  logic                                w_last;
  logic                                w_capture;
  logic                                w_drop;
  logic [LANES-1:0][DATA_WIDTH-1:0]    w_lane_i;
  logic [LANES-1:0][DATA_WIDTH-1:0]    w_lane_q;

  assign w_stream  = (r_state == S_STREAM);
  assign w_hs      = w_stream & bus.dout_ready;
  assign w_last    = (r_beat == LAST_BEAT);
  // A load is taken when idle or exactly on the last-beat handshake; any
  // other load while streaming is dropped and flagged.
  assign w_capture = bus.load & (~w_stream | (w_hs & w_last));
  assign w_drop    = bus.load & w_stream & ~(w_hs & w_last);

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (bus.load) w_next = S_STREAM;
      S_STREAM: if (w_hs && w_last && !bus.load) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Frame buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_buf_i <= '0;
      r_buf_q <= '0;
    end else if (w_capture) begin
      r_buf_i <= bus.din_i;
      r_buf_q <= bus.din_q;
    end
  end

  // Beat counter; wraps to 0 after the last beat so IDLE reports beat 0
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_beat <= '0;
    end else if (w_capture) begin
      r_beat <= '0;
    end else if (w_hs) begin
      r_beat <= w_last ? '0 : r_beat + 1'b1;
    end
  end

  // Sticky overrun flag; set has priority over clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)            r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  ser_lane_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .N_POINTS   (N_POINTS),
    .LANES      (LANES),
    .BEAT_W     (BEAT_W)
  ) u_lane_mux (
    .i_buf_i  (r_buf_i),
    .i_buf_q  (r_buf_q),
    .i_beat   (r_beat),
    .o_lane_i (w_lane_i),
    .o_lane_q (w_lane_q)
  );

  // Output logic: everything derives from registered state only
  always_comb begin
    bus.dout_valid = 1'b0;
    bus.dout_sof   = 1'b0;
    bus.dout_eof   = 1'b0;
    bus.beat_idx   = '0;
    bus.dout_i     = '0;
    bus.dout_q     = '0;
    busy           = 1'b0;
    overrun        = r_overrun;
    if (w_stream) begin
      bus.dout_valid = 1'b1;
      bus.dout_sof   = (r_beat == '0);
      bus.dout_eof   = w_last;
      bus.beat_idx   = r_beat;
      bus.dout_i     = w_lane_i;
      bus.dout_q     = w_lane_q;
      busy           = 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_out_serializer.sv
// Self-checking bench for fft_out_serializer. Expected beats come from a
// frame-level model: beat b, lane l carries frame sample b*LANES + l.
module tb_fft_out_serializer;
  import fft_pkg::*;

  localparam int DW = 13;
  localparam int N  = 512;
  localparam int L  = 16;
  localparam int NB = N / L;
  localparam int BW = 5;

  typedef logic [L-1:0][DW-1:0] beat_t;

  logic clk;
  logic rstn;
  logic busy;
  logic overrun;
  logic clr_overrun;

  int checks;
  int errors;

  int mi[N];
  int mq[N];
  int ni[N];
  int nq[N];

  fft_out_serializer_if #(.DATA_WIDTH(DW), .N_POINTS(N), .LANES(L)) bus ();

  fft_out_serializer #(.DATA_WIDTH(DW), .N_POINTS(N), .LANES(L)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- model helpers (no checking) ----------------
  function automatic int rnd_sample();
    sample_t s;
    s = sample_t'($urandom);
    return int'(s);
  endfunction

  function automatic beat_t exp_i(input int b);
    beat_t r;
    for (int l = 0; l < L; l++) r[l] = DW'(mi[b * L + l]);
    return r;
  endfunction

  function automatic beat_t exp_q(input int b);
    beat_t r;
    for (int l = 0; l < L; l++) r[l] = DW'(mq[b * L + l]);
    return r;
  endfunction

  task automatic ramp_frame();
    for (int k = 0; k < N; k++) begin
      mi[k] = k;
      mq[k] = -k;
    end
  endtask

  task automatic rand_frame_m();
    for (int k = 0; k < N; k++) begin
      mi[k] = rnd_sample();
      mq[k] = rnd_sample();
    end
  endtask

  task automatic rand_frame_n();
    for (int k = 0; k < N; k++) begin
      ni[k] = rnd_sample();
      nq[k] = rnd_sample();
    end
  endtask

  task automatic drive_din(input bit use_next);
    for (int k = 0; k < N; k++) begin
      bus.din_i[k] = use_next ? DW'(ni[k]) : DW'(mi[k]);
      bus.din_q[k] = use_next ? DW'(nq[k]) : DW'(mq[k]);
    end
  endtask

  task automatic scramble_din();
    for (int k = 0; k < N; k++) begin
      bus.din_i[k] = DW'($urandom);
      bus.din_q[k] = DW'($urandom);
    end
  endtask

  // Called at a negedge; returns at the negedge after the capture edge.
  task automatic pulse_load();
    drive_din(1'b0);
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
    scramble_din();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rstn            = 1'b0;
    bus.load        = 1'b0;
    bus.dout_ready  = 1'b0;
    clr_overrun     = 1'b0;
    bus.din_i       = '0;
    bus.din_q       = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dout_valid, bus.dout_sof, bus.dout_eof, busy, overrun} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.dout_valid, bus.dout_sof, bus.dout_eof, busy, overrun});
    end
    checks++;
    if (bus.dout_i !== '0 || bus.dout_q !== '0) begin
      errors++;
      $display("FAIL reset_dout: got i=%h q=%h expected 0", bus.dout_i, bus.dout_q);
    end
    checks++;
    if (bus.beat_idx !== '0) begin
      errors++;
      $display("FAIL reset_beat_idx: got %0d expected 0", bus.beat_idx);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.dout_valid, busy} !== 2'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got valid=%b busy=%b expected 0 0", bus.dout_valid, busy);
    end
  endtask

  task automatic test_ramp();
    ramp_frame();
    bus.dout_ready = 1'b1;
    pulse_load();
    for (int b = 0; b < NB; b++) begin
      checks++;
      if ({bus.dout_valid, bus.beat_idx, bus.dout_sof, bus.dout_eof} !==
          {1'b1, BW'(b), (b == 0), (b == NB - 1)}) begin
        errors++;
        $display("FAIL ramp_status b=%0d: got valid=%b idx=%0d sof=%b eof=%b", b,
                 bus.dout_valid, bus.beat_idx, bus.dout_sof, bus.dout_eof);
      end
      checks++;
      if (bus.dout_i !== exp_i(b) || bus.dout_q !== exp_q(b)) begin
        errors++;
        $display("FAIL ramp_data b=%0d: got i=%h expected %h", b, bus.dout_i, exp_i(b));
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.dout_valid, busy} !== 2'b0) begin
      errors++;
      $display("FAIL ramp_end: got valid=%b busy=%b expected 0 0", bus.dout_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    int    nb;
    int    cyc;
    bit    stalled;
    beat_t prev_i;
    beat_t prev_q;
    ramp_frame();
    bus.dout_ready = 1'b0;
    pulse_load();
    nb      = 0;
    cyc     = 0;
    stalled = 1'b0;
    prev_i  = '0;
    prev_q  = '0;
    while (nb < NB && cyc < 400) begin
      bus.dout_ready = (cyc % 3 == 0);
      checks++;
      if ({bus.dout_valid, bus.beat_idx} !== {1'b1, BW'(nb)}) begin
        errors++;
        $display("FAIL bp_order cyc=%0d: got valid=%b idx=%0d expected 1 %0d", cyc,
                 bus.dout_valid, bus.beat_idx, nb);
      end
      checks++;
      if (bus.dout_i !== exp_i(nb) || bus.dout_q !== exp_q(nb)) begin
        errors++;
        $display("FAIL bp_data beat=%0d: got i=%h expected %h", nb, bus.dout_i, exp_i(nb));
      end
      if (stalled) begin
        checks++;
        if (bus.dout_i !== prev_i || bus.dout_q !== prev_q) begin
          errors++;
          $display("FAIL bp_stable beat=%0d: got i=%h held %h", nb, bus.dout_i, prev_i);
        end
      end
      stalled = !bus.dout_ready;
      prev_i  = bus.dout_i;
      prev_q  = bus.dout_q;
      if (bus.dout_ready) nb++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (nb != NB) begin
      errors++;
      $display("FAIL bp_timeout: got %0d beats expected %0d", nb, NB);
    end
    checks++;
    if (bus.dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_end: got valid=%b expected 0", bus.dout_valid);
    end
    bus.dout_ready = 1'b1;
  endtask

  task automatic test_overrun();
    // Dropped load at beat 10 with constant 0x0AA data
    rand_frame_m();
    bus.dout_ready = 1'b1;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_initial: got %b expected 0", overrun);
    end
    pulse_load();
    for (int b = 0; b < NB; b++) begin
      bus.load    = 1'b0;
      clr_overrun = 1'b0;
      checks++;
      if (bus.dout_i !== exp_i(b) || bus.dout_q !== exp_q(b) || bus.beat_idx !== BW'(b)) begin
        errors++;
        $display("FAIL ovr_data b=%0d: got idx=%0d i=%h expected %h", b, bus.beat_idx,
                 bus.dout_i, exp_i(b));
      end
      if (b == 10) begin
        for (int k = 0; k < N; k++) begin
          bus.din_i[k] = 13'h0AA;
          bus.din_q[k] = 13'h0AA;
        end
        bus.load = 1'b1;
      end
      if (b == 11) begin
        checks++;
        if (overrun !== 1'b1) begin
          errors++;
          $display("FAIL ovr_set: got %b expected 1", overrun);
        end
      end
      @(negedge clk);
    end
    bus.load = 1'b0;
    checks++;
    if ({bus.dout_valid, overrun} !== 2'b01) begin
      errors++;
      $display("FAIL ovr_after_frame: got valid=%b overrun=%b expected 0 1", bus.dout_valid, overrun);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear: got %b expected 0", overrun);
    end

    // Drop and clear in the same cycle: set wins
    rand_frame_m();
    pulse_load();
    for (int b = 0; b < NB; b++) begin
      bus.load    = 1'b0;
      clr_overrun = 1'b0;
      checks++;
      if (bus.dout_i !== exp_i(b) || bus.dout_q !== exp_q(b)) begin
        errors++;
        $display("FAIL ovr2_data b=%0d: got i=%h expected %h", b, bus.dout_i, exp_i(b));
      end
      if (b == 3) begin
        scramble_din();
        bus.load    = 1'b1;
        clr_overrun = 1'b1;
      end
      @(negedge clk);
    end
    bus.load    = 1'b0;
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set_wins: got %b expected 1", overrun);
    end
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_clear2: got %b expected 0", overrun);
    end
  endtask

  task automatic test_back_to_back();
    rand_frame_m();
    rand_frame_n();
    bus.dout_ready = 1'b1;
    pulse_load();
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < NB; b++) begin
        bus.load = 1'b0;
        checks++;
        if ({bus.dout_valid, bus.beat_idx, bus.dout_sof, bus.dout_eof} !==
            {1'b1, BW'(b), (b == 0), (b == NB - 1)}) begin
          errors++;
          $display("FAIL b2b_status f=%0d b=%0d: got valid=%b idx=%0d sof=%b eof=%b", f, b,
                   bus.dout_valid, bus.beat_idx, bus.dout_sof, bus.dout_eof);
        end
        checks++;
        if (bus.dout_i !== exp_i(b) || bus.dout_q !== exp_q(b)) begin
          errors++;
          $display("FAIL b2b_data f=%0d b=%0d: got i=%h expected %h", f, b, bus.dout_i, exp_i(b));
        end
        if (f == 0 && b == NB - 1) begin
          drive_din(1'b1);
          bus.load = 1'b1;
        end
        @(negedge clk);
      end
      if (f == 0) begin
        bus.load = 1'b0;
        scramble_din();
        mi = ni;
        mq = nq;
      end
    end
    bus.load = 1'b0;
    checks++;
    if ({bus.dout_valid, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL b2b_end: got valid=%b overrun=%b expected 0 0", bus.dout_valid, overrun);
    end
  endtask

  task automatic test_async_reset();
    rand_frame_m();
    bus.dout_ready = 1'b1;
    pulse_load();
    repeat (5) @(negedge clk);
    checks++;
    if (bus.beat_idx !== BW'(5)) begin
      errors++;
      $display("FAIL arst_pre_idx: got %0d expected 5", bus.beat_idx);
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.dout_valid, busy, bus.dout_sof, bus.dout_eof} !== 4'b0 || bus.beat_idx !== '0 ||
        bus.dout_i !== '0 || bus.dout_q !== '0) begin
      errors++;
      $display("FAIL arst_async: got valid=%b busy=%b idx=%0d i=%h expected all 0",
               bus.dout_valid, busy, bus.beat_idx, bus.dout_i);
    end
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.dout_valid, busy} !== 2'b0) begin
      errors++;
      $display("FAIL arst_idle: got valid=%b busy=%b expected 0 0", bus.dout_valid, busy);
    end
    rand_frame_m();
    pulse_load();
    for (int b = 0; b < NB; b++) begin
      checks++;
      if (bus.beat_idx !== BW'(b) || bus.dout_valid !== 1'b1 ||
          bus.dout_i !== exp_i(b) || bus.dout_q !== exp_q(b)) begin
        errors++;
        $display("FAIL arst_restream b=%0d: got idx=%0d valid=%b i=%h expected %h", b,
                 bus.beat_idx, bus.dout_valid, bus.dout_i, exp_i(b));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random_frames();
    int nb;
    int cyc;
    for (int f = 0; f < 4; f++) begin
      bus.dout_ready = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_frame_m();
      pulse_load();
      nb  = 0;
      cyc = 0;
      while (nb < NB && cyc < 1000) begin
        bus.dout_ready = ($urandom_range(0, 3) != 0);
        checks++;
        if ({bus.dout_valid, bus.beat_idx, bus.dout_sof, bus.dout_eof} !==
            {1'b1, BW'(nb), (nb == 0), (nb == NB - 1)} ||
            bus.dout_i !== exp_i(nb) || bus.dout_q !== exp_q(nb)) begin
          errors++;
          $display("FAIL rand f=%0d beat=%0d: got idx=%0d valid=%b i=%h expected %h", f, nb,
                   bus.beat_idx, bus.dout_valid, bus.dout_i, exp_i(nb));
        end
        if (bus.dout_ready) nb++;
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (nb != NB || bus.dout_valid !== 1'b0 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL rand_end f=%0d: got beats=%0d valid=%b overrun=%b expected %0d 0 0", f,
                 nb, bus.dout_valid, overrun, NB);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_ramp();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_async_reset();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
